// File: rtl/fma_operand_issuer_if.sv
// Request and response streams between the issue logic and the FMA operand issuer.
//
// Both streams use valid/ready handshaking. A transfer happens on a rising clock
// edge where valid and ready are both high. Once the producer raises valid, it
// holds valid and the payload stable until that transfer. Ready may change
// freely and never depends combinationally on valid.
interface fma_operand_issuer_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [WIDTH-1:0]     in_c;
  logic [1:0]           in_rnd;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [TAG_WIDTH-1:0] out_tag;

  // Issue logic side: produces requests and consumes results.
  modport master (
    output in_valid, in_a, in_b, in_c, in_rnd, in_tag,
    input  in_ready,
    input  out_valid, out_result, out_tag,
    output out_ready
  );

  // Issuer side: consumes requests and produces results.
  modport slave (
    input  in_valid, in_a, in_b, in_c, in_rnd, in_tag,
    output in_ready,
    output out_valid, out_result, out_tag,
    input  out_ready
  );
endinterface

// File: rtl/fma_operand_issuer.sv
// Queues FMA operand triples and drives them into a combinational FMA core.
// The operands are held for a fixed settle window, and then the result is
// captured and returned in request order with its tag.
module fma_operand_issuer #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 4,
  parameter int TAG_WIDTH     = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fma_operand_issuer_if.slave     bus,
  output logic [WIDTH-1:0]        fma_a,
  output logic [WIDTH-1:0]        fma_b,
  output logic [WIDTH-1:0]        fma_c,
  output logic [1:0]              fma_rnd,
  input  logic [WIDTH-1:0]        fma_result,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic [1:0]              state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [1:0]           rnd;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  entry_t               head;
  entry_t               entry_in;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [CW-1:0]        counter;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_result_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  // A pop never frees a slot for a push in the same cycle. Ready depends only on level.
  assign bus.in_ready = (level != FULL_LEVEL);
  assign push         = bus.in_valid && bus.in_ready;
  assign entry_in     = '{a: bus.in_a, b: bus.in_b, c: bus.in_c, rnd: bus.in_rnd, tag: bus.in_tag};
  assign head         = mem[rd_ptr];

  // Dequeue when idle with work pending, or when a result leaves and more work is queued.
  assign pop = (level != '0) &&
               ((state == IDLE) || ((state == RESP) && out_valid_q && bus.out_ready));

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign busy           = (state != IDLE) || (level != '0);
  assign state_dbg      = state;

  // FIFO storage. The data needs no reset because the pointers and level gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_in;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Issue FSM: load operands, wait out the settle window, capture, then hold the result until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      tag_q        <= '0;
      fma_a        <= '0;
      fma_b        <= '0;
      fma_c        <= '0;
      fma_rnd      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (level != '0) begin
            fma_a   <= head.a;
            fma_b   <= head.b;
            fma_c   <= head.c;
            fma_rnd <= head.rnd;
            tag_q   <= head.tag;
            counter <= SETTLE_LOAD;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (counter != '0) begin
            counter <= counter - CW'(1);
          end else begin
            out_result_q <= fma_result;
            out_tag_q    <= tag_q;
            out_valid_q  <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (level != '0) begin
              fma_a   <= head.a;
              fma_b   <= head.b;
              fma_c   <= head.c;
              fma_rnd <= head.rnd;
              tag_q   <= head.tag;
              counter <= SETTLE_LOAD;
              state   <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
